// File: rtl/mem_read_seq_m1.sv
// M1 operand read sequencer: walks an M x M operand column-major,
// row-fastest, and flags done once the last skewed bank has read.
module mem_read_seq_m1 #(
    parameter int D_W = 8,
    parameter int N   = 3,
    parameter int M   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   hold,
    output logic [$clog2(M)-1:0]   row,
    output logic [$clog2(M/N)-1:0] column,
    output logic                   rd_en,
    output logic                   busy,
    output logic                   done
);

    localparam int RW   = $clog2(M);
    localparam int CW   = $clog2(M / N);
    localparam int CNTW = $clog2(N + 1);

    localparam logic [RW-1:0] R_LAST = RW'(M - 1);
    localparam logic [CW-1:0] C_LAST = CW'(M / N - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    if ((M % N) != 0 || (M / N) < 2 || D_W < 1) begin : g_bad_cfg
        $error("mem_read_seq_m1: invalid parameters");
    end

    logic [1:0]      state;
    logic [RW-1:0]   r_nxt;
    logic [CW-1:0]   c_nxt;
    logic [CNTW-1:0] cnt;
    logic            last;

    assign last = (r_nxt == R_LAST) && (c_nxt == C_LAST);

    // done is raised from IDLE-bound transitions with busy still high;
    // IDLE then spends one cycle clearing busy before start is honoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r_nxt  <= '0;
            c_nxt  <= '0;
            cnt    <= '0;
            row    <= '0;
            column <= '0;
            rd_en  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy  <= 1'b1;
                        state <= RUN;
                        c_nxt <= '0;
                        if (!hold) begin
                            row    <= '0;
                            column <= '0;
                            rd_en  <= 1'b1;
                            r_nxt  <= RW'(1);
                        end else begin
                            r_nxt <= '0;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        row    <= r_nxt;
                        column <= c_nxt;
                        rd_en  <= 1'b1;
                        if (last) begin
                            if (N == 1) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= DRAIN;
                                cnt   <= CNTW'(N - 1);
                            end
                        end else if (r_nxt == R_LAST) begin
                            r_nxt <= '0;
                            c_nxt <= c_nxt + CW'(1);
                        end else begin
                            r_nxt <= r_nxt + RW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == CNTW'(1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNTW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_seq_m1.sv
// Directed bench for mem_read_seq_m1: M=6/N=3 instance plus an
// M=4/N=1 instance, with hand-derived cycle-by-cycle expectations.
module tb_mem_read_seq_m1;

    logic       clk;
    logic       rst_n;
    logic       start_a, hold_a, start_b, hold_b;
    logic [2:0] row_a;
    logic [0:0] col_a;
    logic       rd_a, busy_a, done_a;
    logic [1:0] row_b;
    logic [1:0] col_b;
    logic       rd_b, busy_b, done_b;

    int nvec = 0;
    int nmis = 0;

    logic [2:0] o_row [0:63];
    logic [0:0] o_col [0:63];
    logic       o_rd  [0:63];
    logic       o_busy[0:63];
    logic       o_done[0:63];

    mem_read_seq_m1 #(.D_W(8), .N(3), .M(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
        .row(row_a), .column(col_a), .rd_en(rd_a),
        .busy(busy_a), .done(done_a)
    );

    mem_read_seq_m1 #(.D_W(8), .N(1), .M(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b),
        .row(row_b), .column(col_b), .rd_en(rd_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Drives DUT A for ncyc cycles and records what each cycle shows.
    task automatic run_a(input int ncyc, input int hlo, input int hhi,
                         input int st_until);
        for (int c = 0; c < ncyc; c++) begin
            start_a = (c < st_until);
            hold_a  = (c >= hlo) && (c <= hhi);
            @(posedge clk);
            #1;
            o_row[c+1]  = row_a;
            o_col[c+1]  = col_a;
            o_rd[c+1]   = rd_a;
            o_busy[c+1] = busy_a;
            o_done[c+1] = done_a;
        end
        start_a = 1'b0;
        hold_a  = 1'b0;
    endtask

    task automatic settle();
        int i;
        i = 0;
        while ((busy_a || busy_b) && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        nvec++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            nmis++;
            $display("FAIL settle busy_a=%b busy_b=%b required 0", busy_a, busy_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nvec++;
        if ({row_a, col_a, rd_a, busy_a, done_a} !== 7'd0) begin
            nmis++;
            $display("FAIL reset_a got %b required 0", {row_a, col_a, rd_a, busy_a, done_a});
        end
        nvec++;
        if ({row_b, col_b, rd_b, busy_b, done_b} !== 7'd0) begin
            nmis++;
            $display("FAIL reset_b got %b required 0", {row_b, col_b, rd_b, busy_b, done_b});
        end
    endtask

    task automatic test_basic();
        int k;
        logic er, ed, eb;
        run_a(17, -1, -1, 1);
        k = 0;
        for (int c = 1; c <= 17; c++) begin
            er = (c >= 1 && c <= 12);
            ed = (c == 14);
            eb = (c >= 1 && c <= 14);
            nvec++;
            if (o_rd[c] !== er || o_done[c] !== ed || o_busy[c] !== eb) begin
                nmis++;
                $display("FAIL basic_ctl c=%0d got rd/done/busy=%b%b%b required %b%b%b",
                         c, o_rd[c], o_done[c], o_busy[c], er, ed, eb);
            end
            if (er) begin
                nvec++;
                if (o_row[c] !== 3'(k % 6) || o_col[c] !== 1'(k / 6)) begin
                    nmis++;
                    $display("FAIL basic_elem c=%0d got (%0d,%0d) required (%0d,%0d)",
                             c, o_row[c], o_col[c], k % 6, k / 6);
                end
                k++;
            end
        end
        settle();
    endtask

    task automatic test_hold();
        int k;
        logic er, ed, eb;
        run_a(19, 3, 5, 1);
        k = 0;
        for (int c = 1; c <= 19; c++) begin
            er = (c >= 1 && c <= 15) && !(c >= 4 && c <= 6);
            ed = (c == 17);
            eb = (c >= 1 && c <= 17);
            nvec++;
            if (o_rd[c] !== er || o_done[c] !== ed || o_busy[c] !== eb) begin
                nmis++;
                $display("FAIL hold_ctl c=%0d got rd/done/busy=%b%b%b required %b%b%b",
                         c, o_rd[c], o_done[c], o_busy[c], er, ed, eb);
            end
            if (er) begin
                nvec++;
                if (o_row[c] !== 3'(k % 6) || o_col[c] !== 1'(k / 6)) begin
                    nmis++;
                    $display("FAIL hold_elem c=%0d got (%0d,%0d) required (%0d,%0d)",
                             c, o_row[c], o_col[c], k % 6, k / 6);
                end
                k++;
            end else if (c >= 4 && c <= 6) begin
                nvec++;
                if (o_row[c] !== 3'd2 || o_col[c] !== 1'd0) begin
                    nmis++;
                    $display("FAIL hold_frozen c=%0d got (%0d,%0d) required (2,0)",
                             c, o_row[c], o_col[c]);
                end
            end
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int k;
        logic er, ed, eb;
        run_a(33, -1, -1, 16);
        k = 0;
        for (int c = 1; c <= 33; c++) begin
            er = (c >= 1 && c <= 12) || (c >= 16 && c <= 27);
            ed = (c == 14) || (c == 29);
            eb = (c >= 1 && c <= 14) || (c >= 16 && c <= 29);
            nvec++;
            if (o_rd[c] !== er || o_done[c] !== ed || o_busy[c] !== eb) begin
                nmis++;
                $display("FAIL b2b_ctl c=%0d got rd/done/busy=%b%b%b required %b%b%b",
                         c, o_rd[c], o_done[c], o_busy[c], er, ed, eb);
            end
            if (er) begin
                nvec++;
                if (o_row[c] !== 3'((k % 12) % 6) || o_col[c] !== 1'((k % 12) / 6)) begin
                    nmis++;
                    $display("FAIL b2b_elem c=%0d got (%0d,%0d) required (%0d,%0d)",
                             c, o_row[c], o_col[c], (k % 12) % 6, (k % 12) / 6);
                end
                k++;
            end
        end
        settle();
    endtask

    task automatic test_start_hold();
        int k;
        logic er, ed, eb;
        run_a(18, 0, 2, 1);
        k = 0;
        for (int c = 1; c <= 18; c++) begin
            er = (c >= 4 && c <= 15);
            ed = (c == 17);
            eb = (c >= 1 && c <= 17);
            nvec++;
            if (o_rd[c] !== er || o_done[c] !== ed || o_busy[c] !== eb) begin
                nmis++;
                $display("FAIL sthold_ctl c=%0d got rd/done/busy=%b%b%b required %b%b%b",
                         c, o_rd[c], o_done[c], o_busy[c], er, ed, eb);
            end
            if (er) begin
                nvec++;
                if (o_row[c] !== 3'(k % 6) || o_col[c] !== 1'(k / 6)) begin
                    nmis++;
                    $display("FAIL sthold_elem c=%0d got (%0d,%0d) required (%0d,%0d)",
                             c, o_row[c], o_col[c], k % 6, k / 6);
                end
                k++;
            end
        end
        settle();
    endtask

    task automatic test_n1();
        int k;
        logic er, ed, eb;
        start_b = 1'b1;
        k = 0;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            er = (c >= 1 && c <= 16);
            ed = (c == 16);
            eb = (c >= 1 && c <= 16);
            nvec++;
            if (rd_b !== er || done_b !== ed || busy_b !== eb) begin
                nmis++;
                $display("FAIL n1_ctl c=%0d got rd/done/busy=%b%b%b required %b%b%b",
                         c, rd_b, done_b, busy_b, er, ed, eb);
            end
            if (er) begin
                nvec++;
                if (row_b !== 2'(k % 4) || col_b !== 2'(k / 4)) begin
                    nmis++;
                    $display("FAIL n1_elem c=%0d got (%0d,%0d) required (%0d,%0d)",
                             c, row_b, col_b, k % 4, k / 4);
                end
                k++;
            end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
        end
        nvec++;
        if (rd_a !== 1'b1 || row_a !== 3'd3 || col_a !== 1'd1) begin
            nmis++;
            $display("FAIL rstmid_pre got rd=%b (%0d,%0d) required 1 (3,1)", rd_a, row_a, col_a);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({row_a, col_a, rd_a, busy_a, done_a} !== 7'd0) begin
            nmis++;
            $display("FAIL rstmid_async got %b required 0", {row_a, col_a, rd_a, busy_a, done_a});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            nvec++;
            if (done_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== 1'b0) begin
                nmis++;
                $display("FAIL rstmid_quiet c=%0d got done/busy/rd=%b%b%b required 000",
                         c, done_a, busy_a, rd_a);
            end
        end
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        nvec++;
        if (rd_a !== 1'b1 || busy_a !== 1'b1 || row_a !== 3'd0 || col_a !== 1'd0) begin
            nmis++;
            $display("FAIL rstmid_restart got rd=%b busy=%b (%0d,%0d) required 1 1 (0,0)",
                     rd_a, busy_a, row_a, col_a);
        end
        settle();
    endtask

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        start_a = 1'b0;
        hold_a  = 1'b0;
        start_b = 1'b0;
        hold_b  = 1'b0;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_hold();
        test_back_to_back();
        test_n1();
        test_reset_mid();
        test_start_hold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
